// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-outstanding memory port.
// Data normally wins; a pending fetch gets the port after STARVE_LIM data grants.
module riscv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  output logic          busy
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate on if_req/d_req
  // BUSY_I | fetch owns the memory port, waiting for mem_ready
  // BUSY_D | data owns the memory port, waiting for mem_ready
  // RESP   | owner's rvalid (and err) is high for this one cycle
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int SW = ($clog2(STARVE_LIM + 1) < 3) ? 3 : $clog2(STARVE_LIM + 1);
  localparam int WW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          if_gnt_q, if_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          pick_data;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pick_data   = d_req && (!if_req || (starve_q < STARVE_MAX));

    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (if_req || d_req) begin
          mem_req_d = 1'b1;
          if (pick_data) begin
            state_d     = BUSY_D;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (if_req && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + SW'(1);
            end
          end else begin
            state_d     = BUSY_I;
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (wait_q == WAIT_LAST) begin
          // Give up: report the error but leave the read data registers alone.
          state_d     = RESP;
          mem_req_d   = 1'b0;
          err_d       = 1'b1;
          if_rvalid_d = (state_q == BUSY_I);
          d_rvalid_d  = (state_q == BUSY_D);
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule
